bcp_implication_dispatch: RTL and testbench

//  Downstream of the BCP engine. Drains the BCP result FIFO; each 32-bit entry is a unit-clause bitmap (bit i = clause i is unit).

---
 rtl/bcp_implication_dispatch_pkg.sv | 22 ++
 rtl/bcp_implication_dispatch_lsb_prio_enc.sv | 30 +++
 rtl/bcp_implication_dispatch.sv | 143 ++++++++++++++
 tb/tb_bcp_implication_dispatch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_implication_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcp_implication_dispatch_pkg
//  Brief    : Shared definitions (bcp_defs) for the BCP implication dispatcher:
//             FSM encodings and default widths.
//  Revision : 1.0  initial release
// ============================================================================
package bcp_implication_dispatch_pkg;

  localparam int c_word_w     = 32;
  localparam int c_idx_w      = 5;
  localparam int c_clause_num = 8;

  // Dispatcher FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    ISSUE = 2'b10
  } dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/bcp_implication_dispatch_lsb_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : lsb_prio_enc
//  Brief    : Combinational lowest-set-bit priority encoder. Returns the index
//             of the lowest set bit of vec and whether any bit is set.
//  Revision : 1.0  initial release
// ============================================================================
module lsb_prio_enc #(
  parameter int CLAUSE_NUM = 8,
  parameter int IDX_W      = 5
) (
  input  logic [CLAUSE_NUM-1:0] vec,
  input  logic                  unused_tie,
  output logic [IDX_W-1:0]      idx,
  output logic                  any_set
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = CLAUSE_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcp_implication_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : bcp_implication_dispatch
//  Brief    : Drains the BCP result FIFO and serialises every set bit of each
//             unit-clause bitmap (lowest index first) into one implication
//             request on a valid/ready interface. flush discards all work.
//             Optional macro IMPL_DISPATCH_STATS_EN adds saturating
//             request/word counters.
//  Revision : 1.0  initial release
// ============================================================================
module bcp_implication_dispatch
  import bcp_implication_dispatch_pkg::*;
#(
  parameter int CLAUSE_NUM = c_clause_num,
  parameter int WORD_W     = c_word_w,
  parameter int IDX_W      = c_idx_w
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dataout,
  output logic              fifo_read,
  output logic              impl_valid,
  output logic [IDX_W-1:0]  impl_clause,
  input  logic              impl_ready,
  output logic              word_done,
  output logic              busy
`ifdef IMPL_DISPATCH_STATS_EN
  ,
  output logic [15:0]       stat_impl_cnt,
  output logic [15:0]       stat_word_cnt
`endif
);

  dispatch_state_t         r_state;
  logic [CLAUSE_NUM-1:0]   r_pending;
  logic                    r_word_done;

  logic [CLAUSE_NUM-1:0]   w_load_bits;
  logic [CLAUSE_NUM-1:0]   w_bit;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any_set;
  logic                    w_last;
  logic                    w_accept;

  // Only the low CLAUSE_NUM bits of a FIFO word carry clause flags
  assign w_load_bits = fifo_dataout[CLAUSE_NUM-1:0];

  generate
    if (WORD_W > CLAUSE_NUM) begin : g_upper_ignored
      logic w_unused_upper;
      assign w_unused_upper = ^fifo_dataout[WORD_W-1:CLAUSE_NUM];
    end
  endgenerate

  lsb_prio_enc #(
    .CLAUSE_NUM (CLAUSE_NUM),
    .IDX_W      (IDX_W)
  ) u_enc (
    .vec        (r_pending),
    .unused_tie (1'b0),
    .idx        (w_idx),
    .any_set    (w_any_set)
  );

  // Single remaining bit means this accept finishes the word
  assign w_last   = (r_pending & (r_pending - 1'b1)) == '0;
  assign w_bit    = {{(CLAUSE_NUM-1){1'b0}}, 1'b1} << w_idx;

  // Pops only from IDLE, and never while flushing or in reset
  assign fifo_read   = reset && (r_state == IDLE) && dispatch_en && !fifo_empty && !flush;
  assign impl_valid  = (r_state == ISSUE) && w_any_set;
  assign impl_clause = w_idx;
  assign w_accept    = impl_valid && impl_ready;
  assign word_done   = r_word_done;
  assign busy        = (r_state != IDLE);

  // Dispatcher FSM: pop, load bitmap, issue one request per set bit
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (flush) begin
        r_state   <= IDLE;
        r_pending <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (fifo_read) begin
              r_state <= LOAD;
            end
          end
          LOAD: begin
            r_pending <= w_load_bits;
            if (w_load_bits == '0) begin
              r_state     <= IDLE;
              r_word_done <= 1'b1;
            end else begin
              r_state <= ISSUE;
            end
          end
          ISSUE: begin
            if (w_accept) begin
              r_pending <= r_pending & ~w_bit;
              if (w_last) begin
                r_state     <= IDLE;
                r_word_done <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= IDLE;
            r_pending <= '0;
          end
        endcase
      end
    end
  end

`ifdef IMPL_DISPATCH_STATS_EN
  // Saturating activity counters; cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_impl_cnt <= '0;
      stat_word_cnt <= '0;
    end else begin
      if (w_accept && (stat_impl_cnt != 16'hFFFF)) begin
        stat_impl_cnt <= stat_impl_cnt + 16'd1;
      end
      if (r_word_done && (stat_word_cnt != 16'hFFFF)) begin
        stat_word_cnt <= stat_word_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcp_implication_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcp_implication_dispatch
//  Brief    : Self-checking bench for bcp_implication_dispatch. A queue-based
//             model of the expected request stream is compared every cycle;
//             directed scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcp_implication_dispatch;

  localparam int CN = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_en;
  logic        flush;
  logic        fifo_empty;
  logic [31:0] fifo_dataout = '0;
  logic        fifo_read;
  logic        impl_valid;
  logic [4:0]  impl_clause;
  logic        impl_ready;
  logic        word_done;
  logic        busy;
`ifdef IMPL_DISPATCH_STATS_EN
  logic [15:0] stat_impl_cnt;
  logic [15:0] stat_word_cnt;
`endif

  bcp_implication_dispatch dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_en  (dispatch_en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_dataout (fifo_dataout),
    .fifo_read    (fifo_read),
    .impl_valid   (impl_valid),
    .impl_clause  (impl_clause),
    .impl_ready   (impl_ready),
    .word_done    (word_done),
    .busy         (busy)
`ifdef IMPL_DISPATCH_STATS_EN
    ,
    .stat_impl_cnt(stat_impl_cnt),
    .stat_word_cnt(stat_word_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Simple BCP FIFO: data appears the cycle after the pop strobe
  logic [31:0] fifo_mem [16];
  int          wp = 0;
  int          rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clock) begin
    if (fifo_read) begin
      fifo_dataout <= fifo_mem[rp % 16];
      rp           <= rp + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  // Observation log shared with the stimulus
  int cyc = 0;
  int pop_cnt = 0, wd_cnt = 0;
  int pop_cyc = 0, wd_cyc = 0, first_valid_cyc = 0;
  int acc_log[$];
  bit prev_valid = 0;
  bit mon_on = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Model: the set bits of the current word still owed to the consumer
  int m_q[$];
  bit m_busy = 0, m_loading = 0, m_wd = 0;
  int m_impl = 0, m_word = 0;

  always @(negedge clock) begin
    if (mon_on) begin
      automatic bit exp_valid = m_busy && !m_loading && (m_q.size() > 0);
      automatic bit exp_rd    = reset && !m_busy && dispatch_en && !fifo_empty && !flush;
      automatic bit acc       = reset && exp_valid && impl_ready;
      automatic bit nwd       = 0;

      chk("fifo_read", fifo_read, exp_rd);
      chk("impl_valid", impl_valid, exp_valid);
      if (exp_valid) chk("impl_clause", impl_clause, m_q[0]);
      if (!reset) chk("reset_clause", impl_clause, 0);
      chk("word_done", word_done, m_wd);
      chk("busy", busy, m_busy);
`ifdef IMPL_DISPATCH_STATS_EN
      chk("stat_impl", stat_impl_cnt, m_impl);
      chk("stat_word", stat_word_cnt, m_word);
`endif

      if (fifo_read) begin pop_cnt++; pop_cyc = cyc; end
      if (word_done) begin wd_cnt++; wd_cyc = cyc; end
      if (impl_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = impl_valid;
      if (impl_valid && impl_ready) acc_log.push_back(int'(impl_clause));

      if (!reset) begin
        m_q.delete(); m_busy = 0; m_loading = 0; m_wd = 0; m_impl = 0; m_word = 0;
      end else begin
        if (acc) m_impl++;
        if (m_wd) m_word++;
        if (flush) begin
          m_q.delete(); m_busy = 0; m_loading = 0;
        end else if (m_loading) begin
          m_loading = 0;
          for (int i = 0; i < CN; i++) if (fifo_dataout[i]) m_q.push_back(i);
          if (m_q.size() == 0) begin m_busy = 0; nwd = 1; end
        end else if (acc) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_busy = 0; nwd = 1; end
        end else if (exp_rd) begin
          m_busy = 1; m_loading = 1;
        end
        m_wd = nwd;
      end
    end
  end

  task automatic drive_sync();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wp % 16] = w;
    wp = wp + 1;
  endtask

  task automatic wait_wd(input int target, input int budget);
    int k = 0;
    while (wd_cnt < target && k < budget) begin
      @(negedge clock); #1; k++;
    end
    if (wd_cnt < target) chk("word_done_timeout", wd_cnt, target);
  endtask

  task automatic chk_log(input string nm, input int exp_v[$]);
    chk({nm, "_count"}, acc_log.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < acc_log.size(); i++)
      chk(nm, acc_log[i], exp_v[i]);
  endtask

  initial begin
    int base_pop, base_wd, k;
`ifdef IMPL_DISPATCH_STATS_EN
    int base_si, base_sw;
`endif
    reset = 0; dispatch_en = 1; flush = 0; impl_ready = 1;
    // Reset held while the FIFO already holds a word
    push(32'h0000_0025);
    @(posedge clock); #1; mon_on = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_pop_cnt", pop_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", impl_valid, 0);
    chk("reset_word_done", word_done, 0);
    reset = 1;

    // Word 0x25 with consumer always ready: 0,2,5
    wait_wd(1, 20);
    chk_log("t2_order", '{0, 2, 5});
    chk("t2_pops", pop_cnt, 1);
    chk("t2_first_valid_lat", first_valid_cyc - pop_cyc, 2);
    chk("t2_word_cycles", wd_cyc - pop_cyc, 5);

    // Word 0x81 with a 3-cycle consumer stall
    drive_sync(); acc_log.delete(); impl_ready = 0; push(32'h0000_0081);
    k = 0;
    while (!impl_valid && k < 10) begin @(negedge clock); #1; k++; end
    chk("t3_valid_seen", impl_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_clause", impl_clause, 0);
      @(negedge clock); #1;
    end
    drive_sync(); impl_ready = 1;
    wait_wd(2, 20);
    chk_log("t3_order", '{0, 7});

    // Only ignored upper bits set: empty word
    drive_sync(); acc_log.delete(); push(32'h0000_FF00);
    wait_wd(3, 20);
    chk("t4_no_requests", acc_log.size(), 0);
    chk("t4_done_lat", wd_cyc - pop_cyc, 2);

    // All-ones word flushed after the third accept
    drive_sync(); acc_log.delete(); push(32'h0000_00FF);
    k = 0;
    while (acc_log.size() < 3 && k < 20) begin @(negedge clock); #1; k++; end
    chk("t5_three_accepts", acc_log.size(), 3);
    drive_sync(); flush = 1; impl_ready = 0;
    drive_sync(); flush = 0;
    @(negedge clock); #1;
    chk("t5_valid_after_flush", impl_valid, 0);
    repeat (3) @(negedge clock);
    #1;
    chk_log("t5_order", '{0, 1, 2});
    chk("t5_no_word_done", wd_cnt, 3);
    drive_sync(); impl_ready = 1; acc_log.delete(); push(32'h0000_0004);
    wait_wd(4, 20);
    chk_log("t5_next_word", '{2});

    // Two words, dispatch_en dropped during the first
    repeat (2) @(posedge clock);
    #1;
    acc_log.delete(); base_pop = pop_cnt; base_wd = wd_cnt;
`ifdef IMPL_DISPATCH_STATS_EN
    base_si = stat_impl_cnt; base_sw = stat_word_cnt;
`endif
    push(32'h0000_0001); push(32'h0000_0080);
    k = 0;
    while (pop_cnt == base_pop && k < 10) begin @(negedge clock); #1; k++; end
    drive_sync(); dispatch_en = 0;
    wait_wd(base_wd + 1, 20);
    repeat (6) @(negedge clock);
    #1;
    chk("t6_held_pops", pop_cnt - base_pop, 1);
    chk("t6_idle_busy", busy, 0);
    drive_sync(); dispatch_en = 1;
    wait_wd(base_wd + 2, 20);
    chk("t6_pops", pop_cnt - base_pop, 2);
    chk_log("t6_order", '{0, 7});
    repeat (3) @(negedge clock);
    #1;
`ifdef IMPL_DISPATCH_STATS_EN
    chk("t6_stat_impl", stat_impl_cnt - base_si, 2);
    chk("t6_stat_word", stat_word_cnt - base_sw, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
